// File: rtl/shot_controller_if.sv
// rtl/shot_controller_if.sv - player/trajectory-side signal bundle for shot_controller
interface shot_controller_if;
    logic       start;
    logic       fire;
    logic       result_valid;
    logic       hit;
    logic       shoot;
    logic [4:0] target_x;
    logic [4:0] target_y;
    logic [1:0] shots_left;
    logic [7:0] score;
    logic [3:0] level;
    logic       busy;
    logic       game_over;

    modport master (
        input  start, fire, result_valid, hit,
        output shoot, target_x, target_y, shots_left, score, level, busy, game_over
    );

    modport slave (
        output start, fire, result_valid, hit,
        input  shoot, target_x, target_y, shots_left, score, level, busy, game_over
    );
endinterface

// File: rtl/shot_controller.sv
// rtl/shot_controller.sv - game-flow sequencer: targets, shot launch, scoring and game end
module shot_controller #(
    parameter int unsigned SHOTS_PER_TARGET = 3,
    parameter int unsigned TIMEOUT          = 63,
    parameter logic [9:0]  LFSR_SEED        = 10'h2A5
) (
    input  logic             clk,
    input  logic             rst,
    shot_controller_if.master bus
);
    localparam logic [1:0] SPT       = 2'(SHOTS_PER_TARGET);
    localparam logic [7:0] TO_CYCLES = 8'(TIMEOUT);
    localparam logic [9:0] SEED      = (LFSR_SEED == 10'd0) ? 10'h001 : LFSR_SEED;

    typedef enum logic [2:0] {IDLE, NEW_TARGET, ARMED, IN_FLIGHT, OVER} state_t;

    state_t     state;
    logic [9:0] lfsr;
    logic [9:0] lfsr_next;
    logic       fire_q;
    logic [7:0] cnt;
    logic       fire_edge;
    logic       shot_done;
    logic       shot_hit;

    assign lfsr_next = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    assign fire_edge = bus.fire & ~fire_q;
    // A result coinciding with the launch cycle is stale and ignored; a result beats the timeout.
    assign shot_done = (state == IN_FLIGHT) &&
                       ((~bus.shoot & bus.result_valid) || (cnt == TO_CYCLES));
    assign shot_hit  = ~bus.shoot & bus.result_valid & bus.hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lfsr           <= SEED;
            fire_q         <= 1'b0;
            cnt            <= 8'd0;
            bus.shoot      <= 1'b0;
            bus.target_x   <= 5'd0;
            bus.target_y   <= 5'd0;
            bus.shots_left <= 2'd0;
            bus.score      <= 8'd0;
            bus.level      <= 4'd0;
            bus.busy       <= 1'b0;
            bus.game_over  <= 1'b0;
        end else begin
            fire_q <= bus.fire;
            case (state)
                IDLE, OVER: begin
                    if (bus.start) begin
                        state          <= NEW_TARGET;
                        bus.score      <= 8'd0;
                        bus.level      <= 4'd0;
                        bus.shots_left <= SPT;
                        bus.game_over  <= 1'b0;
                    end
                end
                NEW_TARGET: begin
                    lfsr         <= lfsr_next;
                    bus.target_x <= lfsr_next[4:0];
                    bus.target_y <= (lfsr_next[9:5] == 5'd0) ? 5'd1 : lfsr_next[9:5];
                    state        <= ARMED;
                end
                ARMED: begin
                    if (fire_edge) begin
                        state          <= IN_FLIGHT;
                        bus.shoot      <= 1'b1;
                        bus.busy       <= 1'b1;
                        bus.shots_left <= bus.shots_left - 2'd1;
                        cnt            <= 8'd0;
                    end
                end
                IN_FLIGHT: begin
                    bus.shoot <= 1'b0;
                    cnt       <= cnt + 8'd1;
                    if (shot_done) begin
                        bus.busy <= 1'b0;
                        if (shot_hit) begin
                            bus.score      <= (bus.score == 8'hFF) ? bus.score : bus.score + 8'd1;
                            bus.level      <= (bus.level == 4'hF) ? bus.level : bus.level + 4'd1;
                            bus.shots_left <= SPT;
                            state          <= NEW_TARGET;
                        end else if (bus.shots_left == 2'd0) begin
                            state         <= OVER;
                            bus.game_over <= 1'b1;
                        end else begin
                            state <= ARMED;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shot_controller.sv
// tb/tb_shot_controller.sv - randomized scoreboard bench for shot_controller
module tb_shot_controller;
    logic clk = 1'b0;
    logic rst;
    shot_controller_if ifc ();

    shot_controller #(
        .SHOTS_PER_TARGET(3),
        .TIMEOUT(63),
        .LFSR_SEED(10'h2A5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tx;
        int ty;
        int sl;
        int sc;
        int lv;
    } shot_rec_t;

    shot_rec_t shot_q[$];
    int        over_sc_q[$];
    int        over_lv_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    int m_lfsr, m_tx, m_ty, m_score, m_level, m_shots;
    bit m_over;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: game rules in plain arithmetic
    task automatic m_reset();
        m_lfsr = 'h2A5; m_tx = 0; m_ty = 0; m_score = 0; m_level = 0; m_shots = 0; m_over = 0;
    endtask

    task automatic m_new_target();
        int fb;
        fb     = ((m_lfsr / 512) + (m_lfsr / 64)) % 2;
        m_lfsr = ((m_lfsr * 2) % 1024) + fb;
        m_tx   = m_lfsr % 32;
        m_ty   = (m_lfsr / 32 == 0) ? 1 : m_lfsr / 32;
    endtask

    task automatic m_new_game();
        m_score = 0; m_level = 0; m_shots = 3; m_over = 0;
        m_new_target();
    endtask

    task automatic m_shot();
        shot_rec_t r;
        m_shots = m_shots - 1;
        r.tx = m_tx; r.ty = m_ty; r.sl = m_shots; r.sc = m_score; r.lv = m_level;
        shot_q.push_back(r);
    endtask

    task automatic m_result(input bit h);
        if (h) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_level = (m_level < 15) ? m_level + 1 : 15;
            m_shots = 3;
            m_new_target();
        end else if (m_shots == 0) begin
            m_over = 1;
            over_sc_q.push_back(m_score);
            over_lv_q.push_back(m_level);
        end
    endtask

    // Monitor: compares whenever the DUT launches a shot or ends a game
    bit prev_shoot = 0;
    bit prev_go    = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.shoot) begin
                chk("shoot_single_cycle", int'(prev_shoot), 0);
                chk("shoot_expected", int'(shot_q.size() > 0), 1);
                if (shot_q.size() > 0) begin
                    shot_rec_t r;
                    r = shot_q.pop_front();
                    chk("shot_target_x", int'(ifc.target_x), r.tx);
                    chk("shot_target_y", int'(ifc.target_y), r.ty);
                    chk("shot_shots_left", int'(ifc.shots_left), r.sl);
                    chk("shot_score", int'(ifc.score), r.sc);
                    chk("shot_level", int'(ifc.level), r.lv);
                end
            end
            if (ifc.game_over && !prev_go) begin
                chk("game_over_expected", int'(over_sc_q.size() > 0), 1);
                if (over_sc_q.size() > 0) begin
                    chk("over_score", int'(ifc.score), over_sc_q.pop_front());
                    chk("over_level", int'(ifc.level), over_lv_q.pop_front());
                end
            end
        end
        prev_shoot = ifc.shoot;
        prev_go    = ifc.game_over;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game();
        ifc.start = 1'b1; tick(); ifc.start = 1'b0;
        m_new_game();
        tick();
    endtask

    task automatic fire_shot();
        ifc.fire = 1'b1; tick(); ifc.fire = 1'b0;
        m_shot();
    endtask

    task automatic respond(input int d, input bit h, input bit glitch);
        ifc.result_valid = glitch; ifc.hit = 1'b1; tick();
        ifc.result_valid = 1'b0; ifc.hit = 1'b0;
        for (int i = 1; i < d; i++) begin
            ifc.fire = 1'($urandom_range(0, 1));
            tick();
        end
        ifc.fire = 1'b0; ifc.result_valid = 1'b1; ifc.hit = h; tick();
        ifc.result_valid = 1'b0; ifc.hit = 1'b0;
        m_result(h);
        tick();
    endtask

    task automatic timeout_shot();
        int busy_cycles;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (!ifc.busy) break;
            busy_cycles++;
            tick();
        end
        m_result(1'b0);
        chk("timeout_busy_cycles", busy_cycles, 64);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_shoot"}, int'(ifc.shoot), 0);
        chk({tag, "_target_x"}, int'(ifc.target_x), 0);
        chk({tag, "_target_y"}, int'(ifc.target_y), 0);
        chk({tag, "_shots_left"}, int'(ifc.shots_left), 0);
        chk({tag, "_score"}, int'(ifc.score), 0);
        chk({tag, "_level"}, int'(ifc.level), 0);
        chk({tag, "_busy"}, int'(ifc.busy), 0);
        chk({tag, "_game_over"}, int'(ifc.game_over), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ifc.start = 0; ifc.fire = 0; ifc.result_valid = 0; ifc.hit = 0;
        rst = 1'b1;
        m_reset();
        repeat (3) tick();
        rst = 1'b0;
        check_all_zero("reset");

        start_game();
        chk("first_target_x", int'(ifc.target_x), m_tx);
        chk("first_target_y", int'(ifc.target_y), m_ty);
        chk("first_shots_left", int'(ifc.shots_left), 3);
        chk("first_score", int'(ifc.score), 0);

        // Held fire yields one shot only
        ifc.fire = 1'b1; tick(); m_shot();
        repeat (9) tick();
        ifc.fire = 1'b0;
        chk("held_fire_shots_left", int'(ifc.shots_left), 2);
        ifc.result_valid = 1'b1; ifc.hit = 1'b1; tick();
        ifc.result_valid = 1'b0; ifc.hit = 1'b0;
        m_result(1'b1);
        tick();
        chk("hit_score", int'(ifc.score), 1);
        chk("hit_level", int'(ifc.level), 1);
        chk("hit_shots_left", int'(ifc.shots_left), 3);
        chk("hit_new_target_x", int'(ifc.target_x), m_tx);
        chk("hit_new_target_y", int'(ifc.target_y), m_ty);

        fire_shot(); respond(5, 1'b1, 1'b0);
        chk("hit5_score", int'(ifc.score), 2);

        // Three misses end the game; later fire is ignored
        for (int i = 0; i < 3; i++) begin
            fire_shot(); respond(3, 1'b0, 1'b1);
        end
        chk("miss_game_over", int'(ifc.game_over), 1);
        chk("miss_score_kept", int'(ifc.score), 2);
        ifc.fire = 1'b1; tick(); ifc.fire = 1'b0; repeat (3) tick();

        // Timeout miss, then result coinciding with the timeout cycle
        start_game();
        fire_shot(); timeout_shot();
        chk("timeout_shots_left", int'(ifc.shots_left), 2);
        fire_shot(); respond(63, 1'b1, 1'b0);
        chk("coincide_hit_score", int'(ifc.score), 1);

        // Reset in flight
        fire_shot(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        m_reset();
        check_all_zero("midflight_reset");
        ifc.result_valid = 1'b1; ifc.hit = 1'b1; tick();
        ifc.result_valid = 1'b0; ifc.hit = 1'b0; tick();
        check_all_zero("post_reset_result");
        start_game();
        chk("reseed_target_x", int'(ifc.target_x), m_tx);
        chk("reseed_target_y", int'(ifc.target_y), m_ty);

        // Saturation of score and level
        for (int i = 0; i < 260; i++) begin
            fire_shot(); respond(1, 1'b1, 1'b0);
        end
        chk("sat_score", int'(ifc.score), 255);
        chk("sat_level", int'(ifc.level), 15);
        for (int i = 0; i < 3; i++) begin
            fire_shot(); respond(2, 1'b0, 1'b0);
        end

        // Randomized games
        for (int g = 0; g < 8; g++) begin
            start_game();
            while (!m_over) begin
                if ($urandom_range(0, 3) == 0) begin
                    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
                end
                fire_shot();
                if ($urandom_range(0, 7) == 0)
                    timeout_shot();
                else
                    respond(int'($urandom_range(1, 63)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
            end
            ifc.fire = 1'b1; tick(); ifc.fire = 1'b0; repeat (2) tick();
        end

        repeat (3) tick();
        chk("shot_queue_drained", shot_q.size(), 0);
        chk("over_queue_drained", over_sc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
